// File: rtl/lfsr_gen_if.sv
// Packed-word output stream of lfsr_gen: the word and its valid/ready handshake.
interface lfsr_gen_if #(
  parameter int OUT_W = 8
);
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci LFSR that packs its serial stream into OUT_W-bit words.
// Define LFSR_GEN_CHECK_EN to add a sequence checker that compares an input stream against a twin LFSR.
module lfsr_gen #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
  parameter logic [WIDTH-1:0] SEED  = 8'h01,
  parameter int               OUT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  output logic             q,
  output logic [WIDTH-1:0] state,
  lfsr_gen_if.master       bus,
  output logic             wrap
`ifdef LFSR_GEN_CHECK_EN
  ,
  input  logic             chk_valid,
  input  logic             chk_bit,
  output logic [15:0]      chk_err_cnt,
  output logic             chk_err
`endif
);

  localparam int               CNT_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(OUT_W - 1);

  logic [WIDTH-1:0] seed_reg;
  logic [WIDTH-1:0] state_nxt;
  logic [WIDTH-1:0] load_val;
  logic [OUT_W-1:0] shreg;
  logic [OUT_W-1:0] shreg_nxt;
  logic [OUT_W:0]   sh_ext;
  logic [CNT_W-1:0] cnt;
  logic             last_bit;
  logic             stall;
  logic             adv;

  assign q = state[WIDTH-1];

  // NOTE: every signal gets a value on every pass through always_comb, so no latch is inferred.
  always_comb begin
    state_nxt = {state[WIDTH-2:0], ^(state & TAPS)};
    load_val  = (seed_in == '0) ? SEED : seed_in;
    last_bit  = (cnt == LAST);
    stall     = bus.out_valid & ~bus.out_ready & last_bit;
    adv       = en & ~load & ~stall;
    // Wide concatenation keeps the shift legal even when OUT_W is 1.
    sh_ext    = {shreg, q};
    shreg_nxt = sh_ext[OUT_W-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= SEED;
      seed_reg      <= SEED;
      shreg         <= '0;
      cnt           <= '0;
      bus.out_data  <= '0;
      bus.out_valid <= 1'b0;
      wrap          <= 1'b0;
    end else if (load) begin
      state         <= load_val;
      seed_reg      <= load_val;
      shreg         <= '0;
      cnt           <= '0;
      bus.out_valid <= 1'b0;
      wrap          <= 1'b0;
    end else begin
      wrap <= adv && (state_nxt == seed_reg);
      if (bus.out_valid && bus.out_ready)
        bus.out_valid <= 1'b0;
      if (adv) begin
        state <= state_nxt;
        shreg <= shreg_nxt;
        // A word completing in a transfer cycle overrides the clear above.
        if (last_bit) begin
          bus.out_data  <= shreg_nxt;
          bus.out_valid <= 1'b1;
          cnt           <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

`ifdef LFSR_GEN_CHECK_EN
  logic [WIDTH-1:0] chk_state;
  logic             chk_miss;

  assign chk_miss = chk_valid & (chk_bit != chk_state[WIDTH-1]);

  always_ff @(posedge clk) begin
    if (reset) begin
      chk_state   <= SEED;
      chk_err_cnt <= '0;
      chk_err     <= 1'b0;
    end else if (load) begin
      chk_state   <= load_val;
      chk_err_cnt <= '0;
      chk_err     <= 1'b0;
    end else begin
      chk_err <= chk_miss;
      if (chk_valid)
        chk_state <= {chk_state[WIDTH-2:0], ^(chk_state & TAPS)};
      if (chk_miss && chk_err_cnt != 16'hFFFF)
        chk_err_cnt <= chk_err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed bench for lfsr_gen: a 4-bit instance for sequence/packing/handshake cases and the default 8-bit instance for wrap period.
module tb_lfsr_gen;

  logic       clk;
  logic       reset;
  logic       en;
  logic       load;
  logic [3:0] seed4;
  logic [7:0] seed8;
  logic       u4_q;
  logic [3:0] u4_state;
  logic       u4_wrap;
  logic       u8_q;
  logic [7:0] u8_state;
  logic       u8_wrap;
  int         checks;
  int         errors;

  lfsr_gen_if #(.OUT_W(4)) bus4 ();
  lfsr_gen_if #(.OUT_W(8)) bus8 ();

`ifdef LFSR_GEN_CHECK_EN
  logic        inject;
  logic        chk_valid4;
  logic        chk_bit4;
  logic [15:0] chk_cnt4;
  logic        chk_err4;
  logic        chk_valid8;
  logic        chk_bit8;
  logic [15:0] chk_cnt8;
  logic        chk_err8;
  assign chk_valid4 = en;
  assign chk_bit4   = u4_q ^ inject;
  assign chk_valid8 = 1'b0;
  assign chk_bit8   = 1'b0;
`endif

  lfsr_gen #(.WIDTH(4), .TAPS(4'hC), .SEED(4'h1), .OUT_W(4)) u4 (
    .clk(clk), .reset(reset), .en(en), .load(load), .seed_in(seed4),
    .q(u4_q), .state(u4_state), .bus(bus4), .wrap(u4_wrap)
`ifdef LFSR_GEN_CHECK_EN
    , .chk_valid(chk_valid4), .chk_bit(chk_bit4), .chk_err_cnt(chk_cnt4), .chk_err(chk_err4)
`endif
  );

  lfsr_gen u8 (
    .clk(clk), .reset(reset), .en(en), .load(load), .seed_in(seed8),
    .q(u8_q), .state(u8_state), .bus(bus8), .wrap(u8_wrap)
`ifdef LFSR_GEN_CHECK_EN
    , .chk_valid(chk_valid8), .chk_bit(chk_bit8), .chk_err_cnt(chk_cnt8), .chk_err(chk_err8)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    en    = 1'b0;
    load  = 1'b0;
    step(2);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    bus4.out_ready = 1'b0;
    do_reset();
    checks++; if (u4_state !== 4'h1) begin errors++; $display("FAIL reset_state4: got %h expected 1", u4_state); end
    checks++; if (u4_q !== 1'b0) begin errors++; $display("FAIL reset_q4: got %b expected 0", u4_q); end
    checks++; if (bus4.out_valid !== 1'b0 || bus4.out_data !== 4'h0) begin errors++; $display("FAIL reset_out4: got valid=%b data=%h expected valid=0 data=0", bus4.out_valid, bus4.out_data); end
    checks++; if (u4_wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap4: got %b expected 0", u4_wrap); end
    checks++; if (u8_state !== 8'h01 || u8_q !== 1'b0 || bus8.out_valid !== 1'b0) begin errors++; $display("FAIL reset_u8: got state=%h q=%b valid=%b expected 01/0/0", u8_state, u8_q, bus8.out_valid); end
  endtask

  task automatic test_sequence();
    logic [3:0] seq [16];
    seq = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA, 4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1};
    bus4.out_ready = 1'b1;
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checks++; if (u4_state !== seq[i]) begin errors++; $display("FAIL seq_state[%0d]: got %h expected %h", i, u4_state, seq[i]); end
      checks++; if (u4_q !== seq[i][3]) begin errors++; $display("FAIL seq_q[%0d]: got %b expected %b", i, u4_q, seq[i][3]); end
      checks++; if (u4_wrap !== (i == 15)) begin errors++; $display("FAIL seq_wrap[%0d]: got %b expected %b", i, u4_wrap, i == 15); end
      checks++; if (bus4.out_valid !== (i == 4 || i == 8 || i == 12)) begin errors++; $display("FAIL seq_valid[%0d]: got %b", i, bus4.out_valid); end
      if (i == 4) begin checks++; if (bus4.out_data !== 4'b0001) begin errors++; $display("FAIL word0: got %b expected 0001", bus4.out_data); end end
      if (i == 8) begin checks++; if (bus4.out_data !== 4'b0011) begin errors++; $display("FAIL word1: got %b expected 0011", bus4.out_data); end end
      if (i == 12) begin checks++; if (bus4.out_data !== 4'b0101) begin errors++; $display("FAIL word2: got %b expected 0101", bus4.out_data); end end
      if (i < 15) step();
    end
    step();
    checks++; if (u4_wrap !== 1'b0 || u4_state !== 4'h2) begin errors++; $display("FAIL wrap_oneshot: got wrap=%b state=%h expected 0/2", u4_wrap, u4_state); end
  endtask

  task automatic test_stall();
    bus4.out_ready = 1'b0;
    do_reset();
    en = 1'b1;
    step(4);
    checks++; if (bus4.out_valid !== 1'b1 || bus4.out_data !== 4'b0001) begin errors++; $display("FAIL stall_word0: got valid=%b data=%b expected 1/0001", bus4.out_valid, bus4.out_data); end
    step(3);
    for (int i = 0; i < 4; i++) begin
      checks++; if (u4_state !== 4'hA || bus4.out_valid !== 1'b1 || bus4.out_data !== 4'b0001) begin errors++; $display("FAIL stall_hold[%0d]: got state=%h valid=%b data=%b expected A/1/0001", i, u4_state, bus4.out_valid, bus4.out_data); end
      step();
    end
    // The four step() calls above left state frozen; now release.
    bus4.out_ready = 1'b1;
    step();
    checks++; if (u4_state !== 4'h5 || bus4.out_valid !== 1'b1 || bus4.out_data !== 4'b0011) begin errors++; $display("FAIL stall_resume: got state=%h valid=%b data=%b expected 5/1/0011", u4_state, bus4.out_valid, bus4.out_data); end
    step();
    checks++; if (u4_state !== 4'hB || bus4.out_valid !== 1'b0) begin errors++; $display("FAIL stall_drain: got state=%h valid=%b expected B/0", u4_state, bus4.out_valid); end
  endtask

  task automatic test_load();
    bus4.out_ready = 1'b1;
    do_reset();
    en = 1'b1;
    step(2);
    load = 1'b1; seed4 = 4'h0;
    step();
    load = 1'b0;
    checks++; if (u4_state !== 4'h1 || bus4.out_valid !== 1'b0 || u4_wrap !== 1'b0) begin errors++; $display("FAIL load_zero: got state=%h valid=%b wrap=%b expected 1/0/0", u4_state, bus4.out_valid, u4_wrap); end
    step(2);
    load = 1'b1; seed4 = 4'h9;
    step();
    load = 1'b0;
    checks++; if (u4_state !== 4'h9 || bus4.out_valid !== 1'b0) begin errors++; $display("FAIL load_nine: got state=%h valid=%b expected 9/0", u4_state, bus4.out_valid); end
    for (int k = 1; k <= 15; k++) begin
      step();
      checks++; if (u4_wrap !== (k == 15)) begin errors++; $display("FAIL load_wrap[%0d]: got %b expected %b", k, u4_wrap, k == 15); end
      if (k == 4) begin checks++; if (bus4.out_valid !== 1'b1 || bus4.out_data !== 4'b1001) begin errors++; $display("FAIL load_word: got valid=%b data=%b expected 1/1001", bus4.out_valid, bus4.out_data); end end
    end
    checks++; if (u4_state !== 4'h9) begin errors++; $display("FAIL load_period: got %h expected 9", u4_state); end
  endtask

  task automatic test_load_in_stall();
    bus4.out_ready = 1'b0;
    do_reset();
    en = 1'b1;
    step(8);
    load = 1'b1; seed4 = 4'h5; bus4.out_ready = 1'b1;
    step();
    load = 1'b0;
    checks++; if (u4_state !== 4'h5 || bus4.out_valid !== 1'b0) begin errors++; $display("FAIL load_wins: got state=%h valid=%b expected 5/0", u4_state, bus4.out_valid); end
  endtask

  task automatic test_en_hold();
    bus4.out_ready = 1'b0;
    do_reset();
    en = 1'b1;
    step(4);
    en = 1'b0;
    step(3);
    checks++; if (u4_state !== 4'h3 || bus4.out_valid !== 1'b1) begin errors++; $display("FAIL en_hold: got state=%h valid=%b expected 3/1", u4_state, bus4.out_valid); end
    bus4.out_ready = 1'b1;
    step();
    checks++; if (u4_state !== 4'h3 || bus4.out_valid !== 1'b0) begin errors++; $display("FAIL en_accept: got state=%h valid=%b expected 3/0", u4_state, bus4.out_valid); end
  endtask

  task automatic test_wrap_8bit();
    int wraps;
    int zeros;
    int first_at;
    int second_at;
    wraps = 0; zeros = 0; first_at = -1; second_at = -1;
    bus8.out_ready = 1'b1;
    do_reset();
    en = 1'b1;
    for (int k = 1; k <= 510; k++) begin
      step();
      if (u8_state == 8'h00) zeros++;
      if (u8_wrap === 1'b1) begin
        wraps++;
        if (first_at < 0) first_at = k; else second_at = k;
      end
    end
    checks++; if (wraps !== 2) begin errors++; $display("FAIL wrap8_count: got %0d expected 2", wraps); end
    checks++; if (first_at !== 255 || second_at !== 510) begin errors++; $display("FAIL wrap8_spacing: got %0d,%0d expected 255,510", first_at, second_at); end
    checks++; if (zeros !== 0) begin errors++; $display("FAIL wrap8_zero: got %0d zero states expected 0", zeros); end
  endtask

`ifdef LFSR_GEN_CHECK_EN
  task automatic test_checker();
    int pulses;
    pulses = 0;
    inject = 1'b0;
    bus4.out_ready = 1'b1;
    do_reset();
    en = 1'b1;
    for (int k = 0; k < 20; k++) begin step(); if (chk_err4 === 1'b1) pulses++; end
    checks++; if (chk_cnt4 !== 16'd0 || pulses !== 0) begin errors++; $display("FAIL chk_clean: got cnt=%0d pulses=%0d expected 0/0", chk_cnt4, pulses); end
    for (int j = 0; j < 3; j++) begin
      inject = 1'b1;
      step();
      if (chk_err4 === 1'b1) pulses++;
      inject = 1'b0;
      for (int k = 0; k < 3; k++) begin step(); if (chk_err4 === 1'b1) pulses++; end
    end
    checks++; if (chk_cnt4 !== 16'd3 || pulses !== 3) begin errors++; $display("FAIL chk_inject: got cnt=%0d pulses=%0d expected 3/3", chk_cnt4, pulses); end
    load = 1'b1; seed4 = 4'h7;
    step();
    load = 1'b0;
    checks++; if (chk_cnt4 !== 16'd0) begin errors++; $display("FAIL chk_load_clear: got %0d expected 0", chk_cnt4); end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1; en = 1'b0; load = 1'b0;
    seed4 = 4'h0; seed8 = 8'h00;
    bus4.out_ready = 1'b0;
    bus8.out_ready = 1'b1;
`ifdef LFSR_GEN_CHECK_EN
    inject = 1'b0;
`endif
    test_reset();
    test_sequence();
    test_stall();
    test_load();
    test_load_in_stall();
    test_en_hold();
    test_wrap_8bit();
`ifdef LFSR_GEN_CHECK_EN
    test_checker();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
